// File: rtl/processor_pkg.sv
// Shared constants for the fetch and load paths: bus widths, the byte order
// of a command word in RAM, and the program loader FSM encoding.
package processor_pkg;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 8;
   localparam int WORD_BYTES = 3;
   localparam int WORD_W     = DATA_W * WORD_BYTES;
   localparam int IDX_W      = 2;

   // Opcode byte sits at the lowest address; the instruction register assembles the same way.
   localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_WORD = 3'd1;
   localparam logic [2:0] ST_WR0       = 3'd2;
   localparam logic [2:0] ST_WR1       = 3'd3;
   localparam logic [2:0] ST_WR2       = 3'd4;
   localparam logic [2:0] ST_DONE      = 3'd5;
   localparam logic [2:0] ST_OVF       = 3'd6;

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready command word stream into the program loader.
interface program_loader_if #(
   parameter int WORD_W = 24
) ();

   logic [WORD_W-1:0] word_in;
   logic              word_valid;
   logic              word_last;
   logic              word_ready;

   modport master (
      output word_in,
      output word_valid,
      output word_last,
      input  word_ready
   );

   modport slave (
      input  word_in,
      input  word_valid,
      input  word_last,
      output word_ready
   );

endinterface

// File: rtl/program_loader_word_serializer.sv
// Load/shift register that hands out one byte of a command word per cycle.
// byte_out is registered, so it already carries the first byte the cycle after load.
module word_serializer #(
   parameter int DATA_W     = 8,
   parameter int WORD_BYTES = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         load,
   input  logic                         shift,
   input  logic [DATA_W*WORD_BYTES-1:0] word_in,
   output logic [DATA_W-1:0]            byte_out,
   output logic [1:0]                   byte_idx
);
   import processor_pkg::*;

   localparam int W = DATA_W * WORD_BYTES;

   logic [W-1:0]      sh_q,   sh_d;
   logic [DATA_W-1:0] byte_q, byte_d;
   logic [1:0]        idx_q,  idx_d;

   always_comb begin
      sh_d   = sh_q;
      byte_d = byte_q;
      idx_d  = idx_q;
      if (load) begin
         idx_d = 2'd0;
         if (BYTE_ORDER_MSB_FIRST) begin
            byte_d = word_in[W-1 -: DATA_W];
            sh_d   = word_in << DATA_W;
         end else begin
            byte_d = word_in[DATA_W-1:0];
            sh_d   = word_in >> DATA_W;
         end
      end else if (shift) begin
         idx_d = idx_q + 2'd1;
         if (BYTE_ORDER_MSB_FIRST) begin
            byte_d = sh_q[W-1 -: DATA_W];
            sh_d   = sh_q << DATA_W;
         end else begin
            byte_d = sh_q[DATA_W-1:0];
            sh_d   = sh_q >> DATA_W;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_q   <= '0;
         byte_q <= '0;
         idx_q  <= '0;
      end else begin
         sh_q   <= sh_d;
         byte_q <= byte_d;
         idx_q  <= idx_d;
      end
   end

   assign byte_out = byte_q;
   assign byte_idx = idx_q;

endmodule

// File: rtl/program_loader.sv
// Streams 24-bit command words into RAM as three consecutive byte writes,
// holding the core in reset while a load session is running.
//
// state     | meaning
// IDLE      | no session since reset
// WAIT_WORD | session open, word_ready high
// WR0..WR2  | writing opcode, middle and low byte of the captured word
// DONE      | last word written, core released
// OVF       | next word would not fit in RAM, core kept in reset
module program_loader #(
   parameter int                  ADDR_W     = processor_pkg::ADDR_W,
   parameter int                  DATA_W     = processor_pkg::DATA_W,
   parameter int                  WORD_BYTES = processor_pkg::WORD_BYTES,
   parameter logic [ADDR_W-1:0]   BASE_ADDR  = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   program_loader_if.slave   ld_if,
   output logic              write_en,
   output logic [ADDR_W-1:0] write_adress,
   output logic [DATA_W-1:0] data_in,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [7:0]        words_loaded
);
   import processor_pkg::*;

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [ADDR_W-1:0] wa_q,    wa_d;
   logic [7:0]        words_q, words_d;
   logic              we_q,    we_d;
   logic              done_q,  done_d;
   logic              ovf_q,   ovf_d;
   logic              hold_q,  hold_d;
   logic              last_q,  last_d;

   logic              ser_load;
   logic              ser_shift;
   logic [1:0]        byte_idx;
   logic [ADDR_W:0]   fit_limit;
   logic              word_fits;

   // Highest start address that still leaves room for a whole word; stops wrap-around.
   assign fit_limit = (ADDR_W+1)'((2**ADDR_W) - WORD_BYTES);
   assign word_fits = ({1'b0, addr_q} <= fit_limit);

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wa_d      = wa_q;
      words_d   = words_q;
      we_d      = 1'b0;
      done_d    = done_q;
      ovf_d     = ovf_q;
      hold_d    = hold_q;
      last_d    = last_q;
      ser_load  = 1'b0;
      ser_shift = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE, ST_OVF: begin
            if (start) begin
               state_d = ST_WAIT_WORD;
               addr_d  = BASE_ADDR;
               words_d = '0;
               done_d  = 1'b0;
               ovf_d   = 1'b0;
               hold_d  = 1'b1;
            end
         end
         ST_WAIT_WORD: begin
            if (ld_if.word_valid) begin
               if (word_fits) begin
                  state_d  = ST_WR0;
                  last_d   = ld_if.word_last;
                  ser_load = 1'b1;
                  we_d     = 1'b1;
                  wa_d     = addr_q;
               end else begin
                  state_d = ST_OVF;
                  ovf_d   = 1'b1;
               end
            end
         end
         ST_WR0, ST_WR1: begin
            state_d   = (state_q == ST_WR0) ? ST_WR1 : ST_WR2;
            ser_shift = 1'b1;
            we_d      = 1'b1;
            wa_d      = addr_q + ADDR_W'(byte_idx) + ADDR_W'(1);
         end
         ST_WR2: begin
            addr_d = addr_q + ADDR_W'(WORD_BYTES);
            if (words_q != 8'hFF) begin
               words_d = words_q + 8'd1;
            end
            if (last_q) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
               hold_d  = 1'b0;
            end else begin
               state_d = ST_WAIT_WORD;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         addr_q  <= BASE_ADDR;
         wa_q    <= '0;
         words_q <= '0;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         hold_q  <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wa_q    <= wa_d;
         words_q <= words_d;
         we_q    <= we_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         hold_q  <= hold_d;
         last_q  <= last_d;
      end
   end

   word_serializer #(
      .DATA_W     (DATA_W),
      .WORD_BYTES (WORD_BYTES)
   ) u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .shift    (ser_shift),
      .word_in  (ld_if.word_in),
      .byte_out (data_in),
      .byte_idx (byte_idx)
   );

   assign ld_if.word_ready = (state_q == ST_WAIT_WORD);
   assign busy             = (state_q == ST_WAIT_WORD) || (state_q == ST_WR0) ||
                             (state_q == ST_WR1) || (state_q == ST_WR2);
   assign write_en         = we_q;
   assign write_adress     = wa_q;
   assign cpu_hold         = hold_q;
   assign done             = done_q;
   assign overflow         = ovf_q;
   assign words_loaded     = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: reset, single word, back-to-back,
// overflow, reset mid-word and restart scenarios.
module tb_program_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       write_en;
   logic [7:0] write_adress;
   logic [7:0] data_in;
   logic       cpu_hold;
   logic       busy;
   logic       done;
   logic       overflow;
   logic [7:0] words_loaded;

   int checks = 0;
   int errors = 0;

   logic [7:0] wr_addr_log[$];
   logic [7:0] wr_data_log[$];

   program_loader_if #(.WORD_W(24)) ld_if ();

   program_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .ld_if        (ld_if),
      .write_en     (write_en),
      .write_adress (write_adress),
      .data_in      (data_in),
      .cpu_hold     (cpu_hold),
      .busy         (busy),
      .done         (done),
      .overflow     (overflow),
      .words_loaded (words_loaded)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (write_en) begin
         wr_addr_log.push_back(write_adress);
         wr_data_log.push_back(data_in);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr_log.delete();
      wr_data_log.delete();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Returns just after the handshake edge; waited = cycles spent with word_ready low.
   task automatic push_word(input logic [23:0] w, input logic l, output int waited);
      waited = 0;
      ld_if.word_in    = w;
      ld_if.word_valid = 1'b1;
      ld_if.word_last  = l;
      while (!ld_if.word_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (waited >= 20) begin
         checks++; errors++;
         $display("FAIL push_word_timeout word=%h", w);
      end
      tick();
      ld_if.word_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      tick();
      checks++;
      if ({write_en, cpu_hold, busy, done, overflow, ld_if.word_ready} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags got %b want 000000",
                  {write_en, cpu_hold, busy, done, overflow, ld_if.word_ready});
      end
      checks++;
      if ({write_adress, data_in, words_loaded} !== 24'h0) begin
         errors++;
         $display("FAIL reset_values got %h want 000000", {write_adress, data_in, words_loaded});
      end
      clear_log();
      ld_if.word_in    = 24'hDEADBE;
      ld_if.word_last  = 1'b1;
      ld_if.word_valid = 1'b1;
      tick(); tick(); tick();
      checks++;
      if (ld_if.word_ready !== 1'b0 || busy !== 1'b0 || wr_addr_log.size() != 0) begin
         errors++;
         $display("FAIL idle_ignores_valid ready=%b busy=%b writes=%0d want 0 0 0",
                  ld_if.word_ready, busy, wr_addr_log.size());
      end
      ld_if.word_valid = 1'b0;
   endtask

   task automatic test_single_word();
      int w;
      clear_log();
      pulse_start();
      checks++;
      if (cpu_hold !== 1'b1 || busy !== 1'b1 || ld_if.word_ready !== 1'b1) begin
         errors++;
         $display("FAIL single_session_open hold=%b busy=%b ready=%b want 1 1 1",
                  cpu_hold, busy, ld_if.word_ready);
      end
      push_word(24'hA1B2C3, 1'b1, w);
      checks++;
      if (write_en !== 1'b1 || write_adress !== 8'h00 || data_in !== 8'hA1 || ld_if.word_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_wr0 got we=%b a=%h d=%h rdy=%b want 1 00 a1 0",
                  write_en, write_adress, data_in, ld_if.word_ready);
      end
      tick();
      checks++;
      if (write_en !== 1'b1 || write_adress !== 8'h01 || data_in !== 8'hB2) begin
         errors++;
         $display("FAIL single_wr1 got we=%b a=%h d=%h want 1 01 b2", write_en, write_adress, data_in);
      end
      tick();
      checks++;
      if (write_en !== 1'b1 || write_adress !== 8'h02 || data_in !== 8'hC3 || done !== 1'b0) begin
         errors++;
         $display("FAIL single_wr2 got we=%b a=%h d=%h done=%b want 1 02 c3 0",
                  write_en, write_adress, data_in, done);
      end
      tick();
      checks++;
      if (done !== 1'b1 || cpu_hold !== 1'b0 || words_loaded !== 8'd1 || write_en !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_done got done=%b hold=%b words=%0d we=%b busy=%b want 1 0 1 0 0",
                  done, cpu_hold, words_loaded, write_en, busy);
      end
      checks++;
      if (wr_addr_log.size() != 3) begin
         errors++;
         $display("FAIL single_write_count got %0d want 3", wr_addr_log.size());
      end
   endtask

   task automatic test_back_to_back();
      int w;
      int bad;
      clear_log();
      pulse_start();
      push_word(24'h010203, 1'b0, w);
      push_word(24'h040506, 1'b1, w);
      checks++;
      if (w != 3) begin
         errors++;
         $display("FAIL b2b_ready_gap got %0d want 3", w);
      end
      tick(); tick(); tick();
      checks++;
      if (done !== 1'b1 || words_loaded !== 8'd2 || cpu_hold !== 1'b0) begin
         errors++;
         $display("FAIL b2b_done got done=%b words=%0d hold=%b want 1 2 0", done, words_loaded, cpu_hold);
      end
      bad = 0;
      for (int i = 0; i < wr_addr_log.size(); i++) begin
         if (wr_addr_log[i] !== 8'(i) || wr_data_log[i] !== 8'(i + 1)) bad++;
      end
      checks++;
      if (wr_addr_log.size() != 6 || bad != 0) begin
         errors++;
         $display("FAIL b2b_writes got count=%0d bad=%0d want 6 0", wr_addr_log.size(), bad);
      end
   endtask

   task automatic test_overflow();
      int w;
      int bad;
      clear_log();
      pulse_start();
      for (int k = 0; k < 86; k++) begin
         push_word({8'(3 * k), 8'(3 * k + 1), 8'(3 * k + 2)}, 1'b0, w);
      end
      checks++;
      if (overflow !== 1'b1 || cpu_hold !== 1'b1 || words_loaded !== 8'd85 ||
          ld_if.word_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL ovf_state got ovf=%b hold=%b words=%0d rdy=%b busy=%b done=%b want 1 1 85 0 0 0",
                  overflow, cpu_hold, words_loaded, ld_if.word_ready, busy, done);
      end
      tick(); tick(); tick(); tick();
      bad = 0;
      for (int i = 0; i < wr_addr_log.size(); i++) begin
         if (wr_addr_log[i] !== 8'(i) || wr_data_log[i] !== 8'(i)) bad++;
      end
      checks++;
      if (wr_addr_log.size() != 255 || bad != 0) begin
         errors++;
         $display("FAIL ovf_writes got count=%0d bad=%0d want 255 0", wr_addr_log.size(), bad);
      end
      checks++;
      if (overflow !== 1'b1 || write_en !== 1'b0) begin
         errors++;
         $display("FAIL ovf_sticky got ovf=%b we=%b want 1 0", overflow, write_en);
      end
   endtask

   task automatic test_reset_mid_word();
      int w;
      clear_log();
      pulse_start();
      checks++;
      if (overflow !== 1'b0 || busy !== 1'b1 || words_loaded !== 8'd0) begin
         errors++;
         $display("FAIL ovf_restart got ovf=%b busy=%b words=%0d want 0 1 0", overflow, busy, words_loaded);
      end
      push_word(24'h112233, 1'b1, w);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (write_en !== 1'b0 || busy !== 1'b0 || cpu_hold !== 1'b0 || done !== 1'b0 ||
          ld_if.word_ready !== 1'b0 || write_adress !== 8'h00 || data_in !== 8'h00) begin
         errors++;
         $display("FAIL midrst_state got we=%b busy=%b hold=%b done=%b rdy=%b a=%h d=%h want 0 0 0 0 0 00 00",
                  write_en, busy, cpu_hold, done, ld_if.word_ready, write_adress, data_in);
      end
      tick(); tick(); tick();
      checks++;
      if (wr_addr_log.size() != 1 || wr_addr_log[0] !== 8'h00 || wr_data_log[0] !== 8'h11) begin
         errors++;
         $display("FAIL midrst_writes got count=%0d want 1 write 00:11", wr_addr_log.size());
      end
   endtask

   task automatic test_restart();
      int w;
      int bad;
      pulse_start();
      push_word(24'hAABBCC, 1'b1, w);
      tick(); tick(); tick();
      checks++;
      if (done !== 1'b1 || words_loaded !== 8'd1) begin
         errors++;
         $display("FAIL restart_first_done got done=%b words=%0d want 1 1", done, words_loaded);
      end
      clear_log();
      pulse_start();
      checks++;
      if (done !== 1'b0 || words_loaded !== 8'd0 || busy !== 1'b1 || cpu_hold !== 1'b1) begin
         errors++;
         $display("FAIL restart_cleared got done=%b words=%0d busy=%b hold=%b want 0 0 1 1",
                  done, words_loaded, busy, cpu_hold);
      end
      push_word(24'h0D0E0F, 1'b0, w);
      start = 1'b1;
      tick(); tick(); tick();
      start = 1'b0;
      checks++;
      if (ld_if.word_ready !== 1'b1 || busy !== 1'b1 || words_loaded !== 8'd1 || done !== 1'b0) begin
         errors++;
         $display("FAIL restart_start_ignored got rdy=%b busy=%b words=%0d done=%b want 1 1 1 0",
                  ld_if.word_ready, busy, words_loaded, done);
      end
      push_word(24'h102030, 1'b1, w);
      tick(); tick(); tick();
      checks++;
      if (done !== 1'b1 || words_loaded !== 8'd2) begin
         errors++;
         $display("FAIL restart_done got done=%b words=%0d want 1 2", done, words_loaded);
      end
      bad = 0;
      for (int i = 0; i < wr_addr_log.size(); i++) begin
         if (wr_addr_log[i] !== 8'(i)) bad++;
      end
      checks++;
      if (wr_addr_log.size() != 6 || bad != 0 || wr_data_log[0] !== 8'h0D || wr_data_log[3] !== 8'h10 ||
          wr_data_log[5] !== 8'h30) begin
         errors++;
         $display("FAIL restart_writes got count=%0d bad=%0d want 6 0 with data 0d..10..30",
                  wr_addr_log.size(), bad);
      end
   endtask

   initial begin
      ld_if.word_in    = '0;
      ld_if.word_valid = 1'b0;
      ld_if.word_last  = 1'b0;
      test_reset();
      test_single_word();
      test_back_to_back();
      test_overflow();
      test_reset_mid_word();
      test_restart();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
